// File: rtl/riscv_pipe_pkg.sv
// Shared encodings for the 5-stage RISC-V pipeline control logic.
package riscv_pipe_pkg;

    // Forwarding mux selects for the E-stage ALU operands.
    localparam logic [1:0] FWD_RF  = 2'b00;  // register-file value
    localparam logic [1:0] FWD_WB  = 2'b01;  // ResultW
    localparam logic [1:0] FWD_MEM = 2'b10;  // ALUResultM

    // pc_src_e value meaning "no redirect, keep fetching sequentially".
    localparam logic [1:0] PC_SRC_SEQ = 2'b00;

    // Multi-cycle execute sequencer states.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mc_state_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding select: the youngest in-flight writer (M) wins over W,
// and x0 is never forwarded because it is hard-wired to zero.
module hazard_fwd_sel
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic [1:0]        fwd_sel
);

    logic rs_nonzero;
    logic hit_m;
    logic hit_w;

    assign rs_nonzero = (rs != '0);
    assign hit_m      = reg_write_m && (rs == rd_m) && rs_nonzero;
    assign hit_w      = reg_write_w && (rs == rd_w) && rs_nonzero;

    // Priority select: M before W before the register file.
    always_comb begin
        // NOTE: a default is assigned before any branch so every path drives
        // fwd_sel; otherwise synthesis would infer a latch.
        fwd_sel = FWD_RF;
        if (hit_m) begin
            fwd_sel = FWD_MEM;
        end else if (hit_w) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: load-use and RAW
// stalls, redirect flushes, operand forwarding, and a hold sequencer that keeps
// a multi-cycle execute op in E while bubbles are injected into M.
module riscv_hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MC_LATENCY = 4,   // cycles a MUL/DIV occupies E, 2..255
    parameter bit FWD_EN     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_e,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    input  logic              load_e,
    input  logic [1:0]        pc_src_e,
    input  logic              mc_start_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              bubble_m,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              mc_busy,
    output logic              mc_done
);

    // The start cycle and the done cycle are both spent in E, so the counter
    // covers only the cycles in between.
    localparam logic [7:0] MC_CNT_INIT = 8'(MC_LATENCY - 2);

    mc_state_e  state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;

    logic       redirect;
    logic       mc_hold;
    logic       mc_last;
    logic       load_use;
    logic       raw_stall;
    logic       hazard_stall;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    function automatic logic reg_hit(input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rd,
                                     input logic              we);
        return we && (rs == rd) && (rs != '0);
    endfunction

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs          (rs1_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .fwd_sel     (fwd_a_raw)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs          (rs2_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .fwd_sel     (fwd_b_raw)
    );

    assign redirect = (pc_src_e != PC_SRC_SEQ);

    // D-stage hazard detection: load-use always, full RAW only without forwarding.
    always_comb begin
        load_use  = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
        raw_stall = 1'b0;
        if (!FWD_EN) begin
            raw_stall = reg_hit(rs1_d, rd_e, reg_write_e) || reg_hit(rs2_d, rd_e, reg_write_e) ||
                        reg_hit(rs1_d, rd_m, reg_write_m) || reg_hit(rs2_d, rd_m, reg_write_m) ||
                        reg_hit(rs1_d, rd_w, reg_write_w) || reg_hit(rs2_d, rd_w, reg_write_w);
        end
        hazard_stall = load_use || raw_stall;
    end

    // Sequencer next-state: a start in IDLE holds immediately; BUSY counts down
    // to the single release (done) cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mc_hold = 1'b0;
        mc_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (mc_start_e && !redirect) begin
                    mc_hold = 1'b1;
                    state_d = BUSY;
                    cnt_d   = MC_CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q != 8'd0) begin
                    mc_hold = 1'b1;
                    cnt_d   = cnt_q - 8'd1;
                end else begin
                    mc_last = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Sequencer state register; reset aborts any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state flops use non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output combine: redirect beats the multi-cycle hold, which beats
    // load-use/RAW; everything is quiet while rst is high.
    always_comb begin
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_e     = 1'b0;
        flush_d     = 1'b0;
        flush_e     = 1'b0;
        bubble_m    = 1'b0;
        forward_a_e = FWD_RF;
        forward_b_e = FWD_RF;
        mc_busy     = 1'b0;
        mc_done     = 1'b0;
        if (!rst) begin
            stall_f  = !redirect && (mc_hold || hazard_stall);
            stall_d  = !redirect && (mc_hold || hazard_stall);
            stall_e  = mc_hold;
            bubble_m = mc_hold;
            flush_d  = redirect;
            // The held multi-cycle op lives in ID/EX, so it must not be cleared.
            flush_e  = redirect || (hazard_stall && !mc_hold);
            if (FWD_EN) begin
                forward_a_e = fwd_a_raw;
                forward_b_e = fwd_b_raw;
            end
            mc_busy = (state_q == BUSY);
            mc_done = mc_last;
        end
    end

endmodule
